// File: rtl/baud_gen_frac_pkg.sv
// Shared UART package.
// Holds the default clock and baud-rate constants and the helper that turns
// them into a fixed-point oversample divisor. The result has FRAC_W fractional
// bits and is rounded to the nearest value.
package baud_gen_frac_pkg;

    localparam int DEFAULT_CLK_FREQ  = 50_000_000;
    localparam int DEFAULT_BAUD_RATE = 115200;

    // Rounded divisor: (clk_freq * 2^frac_w + rate/2) / rate,
    // where rate = baud_rate * oversample.
    // The result holds the integer part above bit frac_w and the fraction below it.
    function automatic longint calc_def_fx(input longint clk_freq,
                                           input longint baud_rate,
                                           input longint oversample,
                                           input int     frac_w);
        longint denom;
        longint numer;
        denom = baud_rate * oversample;
        numer = clk_freq * (longint'(1) << frac_w) + denom / 2;
        return numer / denom;
    endfunction

endpackage

// File: rtl/frac_div_core.sv
// Fractional period counter.
// Each period lasts div_int + c cycles. A div_int below 2 is treated as 2.
// c is the carry out of an FRAC_W-bit phase accumulator that adds div_frac
// once per period.
//
// Ports:
//   clk, reset  - rising-edge clock, asynchronous active-high reset
//   en          - run enable; when low, the counter and accumulator hold at zero
//   div_int     - integer period, in clk cycles
//   div_frac    - fractional period, in units of 1/2^FRAC_W cycle
//   clear_acc   - zero the accumulator at this wrap instead of advancing it
//   wrap        - combinational: this cycle is the last cycle of the period
//   tick        - registered one-cycle pulse, high for the cycle after a wrap
module frac_div_core import baud_gen_frac_pkg::*; #(
    parameter int DIV_W  = 16,
    parameter int FRAC_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    input  logic              clear_acc,
    output logic              wrap,
    output logic              tick
);

    // One extra counter bit keeps a full 2^DIV_W-cycle period representable.
    logic [DIV_W:0]    count;
    logic [FRAC_W-1:0] acc;
    logic [FRAC_W:0]   acc_sum;
    logic [DIV_W-1:0]  eff_int;
    logic [DIV_W:0]    last_count;

    // The carry of this period's accumulator add stretches the period by one cycle.
    always_comb begin
        acc_sum    = {1'b0, acc} + {1'b0, div_frac};
        eff_int    = (div_int < DIV_W'(2)) ? DIV_W'(2) : div_int;
        last_count = {1'b0, eff_int} + {{DIV_W{1'b0}}, acc_sum[FRAC_W]}
                     - {{DIV_W{1'b0}}, 1'b1};
        wrap       = en && (count == last_count);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            acc   <= '0;
            tick  <= 1'b0;
        end else if (!en) begin
            count <= '0;
            acc   <= '0;
            tick  <= 1'b0;
        end else if (wrap) begin
            count <= '0;
            acc   <= clear_acc ? '0 : acc_sum[FRAC_W-1:0];
            tick  <= 1'b1;
        end else begin
            count <= count + {{DIV_W{1'b0}}, 1'b1};
            tick  <= 1'b0;
        end
    end

endmodule

// File: rtl/baud_gen_frac.sv
// Fractional baud-rate generator.
// Produces an oversample tick (os_tick) from a fixed-point divisor. It also
// produces a bit-period tick (baud_tick) once every OVERSAMPLE os_ticks.
// A new divisor is written through a valid/ready handshake into a shadow
// register. While the generator runs, the new divisor takes effect at the next
// os-period boundary. While the generator is idle, it takes effect at once.
//
// Ports:
//   clk, reset    - rising-edge clock, asynchronous active-high reset
//   en            - run enable; dropping it realigns the tick phase
//   cfg_valid     - request to load cfg_div_int / cfg_div_frac
//   cfg_div_int   - integer part of the oversample divisor, in clk cycles
//   cfg_div_frac  - fractional part, in units of 1/2^FRAC_W cycle
//   cfg_ready     - high when a new divisor can be accepted
//   os_tick       - one-cycle oversample pulse
//   baud_tick     - one-cycle bit-period pulse, coincident with an os_tick
module baud_gen_frac import baud_gen_frac_pkg::*; #(
    parameter int CLK_FREQ   = DEFAULT_CLK_FREQ,
    parameter int BAUD_RATE  = DEFAULT_BAUD_RATE,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_W      = 16,
    parameter int FRAC_W     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              cfg_valid,
    input  logic [DIV_W-1:0]  cfg_div_int,
    input  logic [FRAC_W-1:0] cfg_div_frac,
    output logic              cfg_ready,
    output logic              os_tick,
    output logic              baud_tick
);

    localparam longint DEF_FX = calc_def_fx(CLK_FREQ, BAUD_RATE, OVERSAMPLE, FRAC_W);
    localparam logic [DIV_W-1:0]  DEF_INT  = DIV_W'(DEF_FX >> FRAC_W);
    localparam logic [FRAC_W-1:0] DEF_FRAC = FRAC_W'(DEF_FX);
    localparam int OS_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);

    logic [DIV_W-1:0]  act_int;
    logic [FRAC_W-1:0] act_frac;
    logic [DIV_W-1:0]  shadow_int;
    logic [FRAC_W-1:0] shadow_frac;
    logic              pending;
    logic [OS_W-1:0]   os_cnt;
    logic              wrap;
    logic              accept;
    logic              load_now;

    // A pending divisor is applied at once while idle. While running, it waits
    // for a period boundary so the running period is never altered.
    always_comb begin
        cfg_ready = !pending;
        accept    = cfg_valid && !pending;
        load_now  = pending && (!en || wrap);
    end

    frac_div_core #(
        .DIV_W  (DIV_W),
        .FRAC_W (FRAC_W)
    ) u_core (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .div_int   (act_int),
        .div_frac  (act_frac),
        .clear_acc (load_now),
        .wrap      (wrap),
        .tick      (os_tick)
    );

    // The shadow register and pending flag hold at most one outstanding request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_int  <= DEF_INT;
            shadow_frac <= DEF_FRAC;
            pending     <= 1'b0;
        end else if (accept) begin
            shadow_int  <= cfg_div_int;
            shadow_frac <= cfg_div_frac;
            pending     <= 1'b1;
        end else if (load_now) begin
            pending     <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            act_int  <= DEF_INT;
            act_frac <= DEF_FRAC;
        end else if (load_now) begin
            act_int  <= shadow_int;
            act_frac <= shadow_frac;
        end
    end

    // A period boundary that also loads a new divisor restarts the group count.
    // That boundary still completes the current group if it is the last os_tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            os_cnt    <= '0;
            baud_tick <= 1'b0;
        end else if (!en) begin
            os_cnt    <= '0;
            baud_tick <= 1'b0;
        end else if (wrap) begin
            baud_tick <= (os_cnt == OS_LAST);
            if (load_now || os_cnt == OS_LAST) begin
                os_cnt <= '0;
            end else begin
                os_cnt <= os_cnt + OS_W'(1);
            end
        end else begin
            baud_tick <= 1'b0;
        end
    end

endmodule

// File: tb/tb_baud_gen_frac.sv
// Directed self-checking bench for baud_gen_frac with default parameters.
// Tick timestamps are taken on the falling edge. Each timestamp is the number of
// rising edges seen so far. All interval expectations are hand-computed.
module tb_baud_gen_frac;

    localparam int DIV_W  = 16;
    localparam int FRAC_W = 4;

    logic              clk;
    logic              reset;
    logic              en;
    logic              cfg_valid;
    logic [DIV_W-1:0]  cfg_div_int;
    logic [FRAC_W-1:0] cfg_div_frac;
    logic              cfg_ready;
    logic              os_tick;
    logic              baud_tick;

    int testsRun;
    int failCount;
    int cyc;
    int osStamps[$];
    int baudStamps[$];

    baud_gen_frac dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .cfg_valid    (cfg_valid),
        .cfg_div_int  (cfg_div_int),
        .cfg_div_frac (cfg_div_frac),
        .cfg_ready    (cfg_ready),
        .os_tick      (os_tick),
        .baud_tick    (baud_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record the timestamp of every tick.
    always @(negedge clk) begin
        if (os_tick)   osStamps.push_back(cyc);
        if (baud_tick) baudStamps.push_back(cyc);
    end

    task automatic checkOutput(input string tag, input longint actual, input longint expected);
        testsRun++;
        if (actual != expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic enV, input logic validV, input int divI, input int divF);
        en           = enV;
        cfg_valid    = validV;
        cfg_div_int  = DIV_W'(divI);
        cfg_div_frac = FRAC_W'(divF);
    endtask

    task automatic stepCycles(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    function automatic int osAt(input int i);
        return (i < osStamps.size()) ? osStamps[i] : -1;
    endfunction

    function automatic int baudAt(input int i);
        return (i < baudStamps.size()) ? baudStamps[i] : -1;
    endfunction

    // Wait, bounded, until enough ticks have been recorded.
    task automatic waitQueues(input int nOs, input int nBaud, input int limit);
        int k;
        k = 0;
        while ((osStamps.size() < nOs || baudStamps.size() < nBaud) && k < limit) begin
            stepCycles(1);
            k++;
        end
        if (osStamps.size() < nOs)     checkOutput("timeout_os", osStamps.size(), nOs);
        if (baudStamps.size() < nBaud) checkOutput("timeout_baud", baudStamps.size(), nBaud);
    endtask

    task automatic startRun(output int start);
        applyStimulus(1'b1, 1'b0, 0, 0);
        osStamps.delete();
        baudStamps.delete();
        start = cyc;
    endtask

    task automatic stopRun();
        applyStimulus(1'b0, 1'b0, 0, 0);
        stepCycles(2);
    endtask

    // Load a divisor while idle; it becomes active one cycle after capture.
    task automatic loadIdle(input int divI, input int divF);
        applyStimulus(1'b0, 1'b1, divI, divF);
        stepCycles(1);
        checkOutput("idle_ready_drop", cfg_ready, 0);
        applyStimulus(1'b0, 1'b0, divI, divF);
        stepCycles(1);
        checkOutput("idle_ready_back", cfg_ready, 1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int start;
        int sw;
        testsRun  = 0;
        failCount = 0;
        cyc       = 0;
        reset     = 1'b1;
        applyStimulus(1'b0, 1'b0, 0, 0);
        stepCycles(2);
        checkOutput("reset_os_tick", os_tick, 0);
        checkOutput("reset_baud_tick", baud_tick, 0);
        checkOutput("reset_cfg_ready", cfg_ready, 1);
        reset = 1'b0;
        stepCycles(2);

        // Default divisor 27 + 2/16: period 7 is the stretched one; 16 periods total 434 cycles.
        startRun(start);
        waitQueues(33, 2, 1200);
        checkOutput("def_first_period", osAt(0) - start, 27);
        checkOutput("def_period1", osAt(1) - osAt(0), 27);
        checkOutput("def_period7", osAt(7) - osAt(6), 28);
        checkOutput("def_16_periods", osAt(15) - start, 434);
        checkOutput("def_first_baud", baudAt(0) - start, 434);
        checkOutput("def_baud_period", baudAt(1) - baudAt(0), 434);
        checkOutput("def_baud_on_os", baudAt(0), osAt(15));

        // Disabled: no ticks at all.
        stopRun();
        osStamps.delete();
        stepCycles(20);
        checkOutput("en0_quiet", osStamps.size(), 0);

        // int 4, frac 0.
        loadIdle(4, 0);
        startRun(start);
        waitQueues(17, 2, 300);
        checkOutput("d4_first", osAt(0) - start, 4);
        checkOutput("d4_period", osAt(1) - osAt(0), 4);
        checkOutput("d4_first_baud", baudAt(0) - start, 64);
        checkOutput("d4_baud_period", baudAt(1) - baudAt(0), 64);

        // int 4, frac 8: periods alternate 4, 5.
        stopRun();
        loadIdle(4, 8);
        startRun(start);
        waitQueues(17, 2, 300);
        checkOutput("d48_p0", osAt(0) - start, 4);
        checkOutput("d48_p1", osAt(1) - osAt(0), 5);
        checkOutput("d48_p2", osAt(2) - osAt(1), 4);
        checkOutput("d48_p3", osAt(3) - osAt(2), 5);
        checkOutput("d48_first_baud", baudAt(0) - start, 72);
        checkOutput("d48_baud_period", baudAt(1) - baudAt(0), 72);

        // Load int 10 one cycle into a period of 4; the switch lands on the 4th tick.
        stopRun();
        loadIdle(4, 0);
        startRun(start);
        waitQueues(3, 0, 100);
        stepCycles(1);
        applyStimulus(1'b1, 1'b1, 10, 0);
        stepCycles(1);
        checkOutput("sw_ready_low1", cfg_ready, 0);
        checkOutput("sw_no_tick1", os_tick, 0);
        applyStimulus(1'b1, 1'b0, 10, 0);
        stepCycles(1);
        checkOutput("sw_ready_low2", cfg_ready, 0);
        checkOutput("sw_no_tick2", os_tick, 0);
        stepCycles(1);
        checkOutput("sw_tick", os_tick, 1);
        checkOutput("sw_ready_back", cfg_ready, 1);
        sw = cyc;
        checkOutput("sw_old_period", sw - osAt(2), 4);
        checkOutput("sw_no_early_baud", baudStamps.size(), 0);
        osStamps.delete();
        baudStamps.delete();
        waitQueues(2, 1, 400);
        checkOutput("sw_new_p0", osAt(0) - sw, 10);
        checkOutput("sw_new_p1", osAt(1) - osAt(0), 10);
        checkOutput("sw_baud_after", baudAt(0) - sw, 160);

        // int 1 behaves as 2; a second request while busy is dropped.
        stopRun();
        applyStimulus(1'b0, 1'b1, 1, 0);
        stepCycles(1);
        checkOutput("i1_ready_low", cfg_ready, 0);
        applyStimulus(1'b0, 1'b1, 7, 0);
        stepCycles(1);
        checkOutput("i1_ready_back", cfg_ready, 1);
        applyStimulus(1'b0, 1'b0, 7, 0);
        stepCycles(1);
        startRun(start);
        waitQueues(17, 1, 200);
        checkOutput("i1_first", osAt(0) - start, 2);
        checkOutput("i1_period", osAt(1) - osAt(0), 2);
        checkOutput("i1_first_baud", baudAt(0) - start, 32);

        // Asynchronous reset mid-period with a load pending.
        stopRun();
        loadIdle(4, 0);
        startRun(start);
        waitQueues(1, 0, 50);
        applyStimulus(1'b1, 1'b1, 20, 0);
        stepCycles(1);
        checkOutput("rst_pending_ready", cfg_ready, 0);
        applyStimulus(1'b1, 1'b0, 20, 0);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("rst_async_ready", cfg_ready, 1);
        checkOutput("rst_async_os", os_tick, 0);
        checkOutput("rst_async_baud", baud_tick, 0);
        applyStimulus(1'b0, 1'b0, 0, 0);
        stepCycles(2);
        reset = 1'b0;
        stepCycles(1);
        checkOutput("rst_release_ready", cfg_ready, 1);
        startRun(start);
        waitQueues(2, 0, 100);
        checkOutput("rst_default_p0", osAt(0) - start, 27);
        checkOutput("rst_default_p1", osAt(1) - osAt(0), 27);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
